// File: rtl/axil_pkg.sv
// Shared AXI4-Lite response codes and FSM state types for the RAM slave.
package axil_pkg;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  typedef enum logic [1:0] {R_IDLE, R_DLY, R_RESP} r_state_t;
  typedef enum logic [1:0] {W_ADDR, W_DLY, W_RESP} w_state_t;

  function automatic logic [1:0] resp_of(input logic good);
    return good ? OKAY : DECERR;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR, x^16+x^14+x^13+x^11+1, stepping every cycle out of reset.
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] q
);

  always_ff @(posedge clk) begin
    if (rst) q <= SEED;
    else     q <= {1'b0, q[15:1]} ^ (q[0] ? 16'hB400 : 16'h0000);
  end

endmodule

// File: rtl/axil_ram_slave.sv
// AXI4-Lite RAM slave: windowed decode, strobed writes, fixed or LFSR-driven
// per-transaction response latency, independent read and write channels.
module axil_ram_slave
  import axil_pkg::*;
#(
  parameter int          DATA_W     = 32,
  parameter logic [31:0] BASE       = 32'h8000_0000,
  parameter int          DEPTH_LOG2 = 12,
  parameter int          DLY_W      = 2,
  parameter int          RAND_DLY   = 1,
  parameter int          FIX_DLY    = 0,
  parameter logic [15:0] SEED       = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              awvalid,
  output logic              awready,
  input  logic [31:0]       awaddr,
  input  logic              wvalid,
  output logic              wready,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  output logic              bvalid,
  input  logic              bready,
  output logic [1:0]        bresp,
  input  logic              arvalid,
  output logic              arready,
  input  logic [31:0]       araddr,
  output logic              rvalid,
  input  logic              rready,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        rresp
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = (BYTES > 1) ? $clog2(BYTES) : 0;
  localparam int IDX_W = DEPTH_LOG2;
  localparam logic [31:0] WIN_MASK = ~((32'd1 << (IDX_W + OFF_W)) - 32'd1);
  localparam logic [DLY_W-1:0] FIX_D = DLY_W'(FIX_DLY);
  localparam logic [DLY_W-1:0] ONE   = DLY_W'(1);

  logic [DATA_W-1:0] mem [2**IDX_W];

  logic [15:0] lfsr;
  logic        lfsr_unused;
  lfsr16 #(.SEED(SEED)) u_lfsr (.clk(clk), .rst(rst), .q(lfsr));
  assign lfsr_unused = ^lfsr;

  logic [DLY_W-1:0] rd_dly, wr_dly;
  assign rd_dly = (RAND_DLY != 0) ? lfsr[DLY_W-1:0]  : FIX_D;
  assign wr_dly = (RAND_DLY != 0) ? lfsr[15 -: DLY_W] : FIX_D;

  // ---------------- read channel ----------------
  r_state_t         r_state, r_next;
  logic [DLY_W-1:0] r_cnt;
  logic [IDX_W-1:0] r_idx, ar_idx, rsel_idx;
  logic             r_good, ar_good, rsel_good, ar_hs, r_load;

  assign arready  = (r_state == R_IDLE);
  assign rvalid   = (r_state == R_RESP);
  assign ar_hs    = arvalid && arready;
  assign ar_idx   = araddr[IDX_W+OFF_W-1:OFF_W];
  assign ar_good  = (araddr & WIN_MASK) == BASE;
  // Zero-delay reads sample memory straight from the live address.
  assign rsel_idx  = (r_state == R_IDLE) ? ar_idx  : r_idx;
  assign rsel_good = (r_state == R_IDLE) ? ar_good : r_good;
  assign r_load    = (r_next == R_RESP) && (r_state != R_RESP);

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs) r_next = (rd_dly == '0) ? R_RESP : R_DLY;
      R_DLY:   if (r_cnt == ONE) r_next = R_RESP;
      R_RESP:  if (rready) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= R_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_good  <= 1'b0;
      rdata   <= '0;
      rresp   <= OKAY;
    end else begin
      r_state <= r_next;
      if (ar_hs) begin
        r_cnt  <= rd_dly;
        r_idx  <= ar_idx;
        r_good <= ar_good;
      end else if (r_state == R_DLY) begin
        r_cnt <= r_cnt - ONE;
      end
      if (r_load) begin
        rdata <= rsel_good ? mem[rsel_idx] : '0;
        rresp <= resp_of(rsel_good);
      end
    end
  end

  // ---------------- write channel ----------------
  w_state_t         w_state, w_next;
  logic [DLY_W-1:0] w_cnt;
  logic             aw_got, w_got, aw_hs, w_hs, w_commit;
  logic [IDX_W-1:0] aw_idx_q, aw_idx, wsel_idx;
  logic             aw_good_q, aw_good, wsel_good;
  logic [DATA_W-1:0] wdata_q, wsel_data;
  logic [BYTES-1:0]  wstrb_q, wsel_strb;

  assign awready  = !aw_got;
  assign wready   = !w_got;
  assign bvalid   = (w_state == W_RESP);
  assign aw_hs    = awvalid && awready;
  assign w_hs     = wvalid && wready;
  assign aw_idx   = awaddr[IDX_W+OFF_W-1:OFF_W];
  assign aw_good  = (awaddr & WIN_MASK) == BASE;
  // Whichever half arrives in the completing cycle is taken from the bus.
  assign wsel_idx  = aw_got ? aw_idx_q  : aw_idx;
  assign wsel_good = aw_got ? aw_good_q : aw_good;
  assign wsel_data = w_got  ? wdata_q   : wdata;
  assign wsel_strb = w_got  ? wstrb_q   : wstrb;
  assign w_commit  = (w_next == W_RESP) && (w_state != W_RESP);

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_ADDR:  if ((aw_got || aw_hs) && (w_got || w_hs))
                 w_next = (wr_dly == '0) ? W_RESP : W_DLY;
      W_DLY:   if (w_cnt == ONE) w_next = W_RESP;
      W_RESP:  if (bready) w_next = W_ADDR;
      default: w_next = W_ADDR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state   <= W_ADDR;
      w_cnt     <= '0;
      aw_got    <= 1'b0;
      w_got     <= 1'b0;
      aw_idx_q  <= '0;
      aw_good_q <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bresp     <= OKAY;
    end else begin
      w_state <= w_next;
      if (aw_hs) begin
        aw_got    <= 1'b1;
        aw_idx_q  <= aw_idx;
        aw_good_q <= aw_good;
      end
      if (w_hs) begin
        w_got   <= 1'b1;
        wdata_q <= wdata;
        wstrb_q <= wstrb;
      end
      if (w_state == W_ADDR && w_next != W_ADDR) w_cnt <= wr_dly;
      else if (w_state == W_DLY)                 w_cnt <= w_cnt - ONE;
      if (w_commit) bresp <= resp_of(wsel_good);
      if (w_state == W_RESP && bready) begin
        aw_got <= 1'b0;
        w_got  <= 1'b0;
      end
    end
  end

  // Memory is never reset; a reset cycle suppresses the commit.
  always_ff @(posedge clk) begin
    if (!rst && w_commit && wsel_good) begin
      for (int b = 0; b < BYTES; b++)
        if (wsel_strb[b]) mem[wsel_idx][8*b +: 8] <= wsel_data[8*b +: 8];
    end
  end

endmodule

// File: tb/tb_axil_ram_slave.sv
// Bench for axil_ram_slave: three instances (fixed 0, fixed 3, random latency)
// checked against directed expectations and a word-array reference model.
module tb_axil_ram_slave;

  localparam int          N    = 3;
  localparam logic [31:0] BASE = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        awvalid [N], awready [N], wvalid [N], wready [N];
  logic        bvalid [N], bready [N], arvalid [N], arready [N];
  logic        rvalid [N], rready [N];
  logic [31:0] awaddr [N], araddr [N], wdata [N], rdata [N];
  logic [3:0]  wstrb [N];
  logic [1:0]  bresp [N], rresp [N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    axil_ram_slave #(
      .RAND_DLY((g == 2) ? 1 : 0),
      .FIX_DLY ((g == 1) ? 3 : 0)
    ) u_dut (
      .clk(clk), .rst(rst),
      .awvalid(awvalid[g]), .awready(awready[g]), .awaddr(awaddr[g]),
      .wvalid(wvalid[g]), .wready(wready[g]), .wdata(wdata[g]), .wstrb(wstrb[g]),
      .bvalid(bvalid[g]), .bready(bready[g]), .bresp(bresp[g]),
      .arvalid(arvalid[g]), .arready(arready[g]), .araddr(araddr[g]),
      .rvalid(rvalid[g]), .rready(rready[g]), .rdata(rdata[g]), .rresp(rresp[g])
    );
  end

  int passed = 0;
  int total  = 0;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Issue one read (rready held high); latency counted in cycles from AR handshake.
  task automatic do_read(input int u, input logic [31:0] a,
                         output logic [31:0] d, output logic [1:0] r, output int lat);
    int n = 0;
    arvalid[u] = 1'b1; araddr[u] = a;
    while (!arready[u] && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    arvalid[u] = 1'b0;
    lat = 1;
    while (!rvalid[u] && lat < 50) begin @(negedge clk); lat++; end
    d = rdata[u]; r = rresp[u];
    @(negedge clk);
  endtask

  // Issue AW and W together; latency counted from the later handshake.
  task automatic do_write(input int u, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, output logic [1:0] r, output int lat);
    bit ad = 0, wd = 0;
    int n = 0;
    awvalid[u] = 1'b1; awaddr[u] = a;
    wvalid[u]  = 1'b1; wdata[u]  = d; wstrb[u] = s;
    while (!(ad && wd) && n < 50) begin
      if (awvalid[u] && awready[u]) ad = 1;
      if (wvalid[u] && wready[u])   wd = 1;
      @(negedge clk); n++;
      if (ad) awvalid[u] = 1'b0;
      if (wd) wvalid[u]  = 1'b0;
    end
    lat = 1;
    while (!bvalid[u] && lat < 50) begin @(negedge clk); lat++; end
    r = bresp[u];
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int u = 0; u < N; u++) begin
      total++;
      if ({arready[u], awready[u], wready[u], rvalid[u], bvalid[u], rresp[u], bresp[u]} !== 9'b111_00_00_00)
        $display("FAIL reset_ctrl u%0d got %b want 111000000", u,
                 {arready[u], awready[u], wready[u], rvalid[u], bvalid[u], rresp[u], bresp[u]});
      else passed++;
      total++;
      if (rdata[u] !== 32'h0) $display("FAIL reset_rdata u%0d got %h want 0", u, rdata[u]);
      else passed++;
    end
  endtask

  task automatic test_basic();
    logic [31:0] d; logic [1:0] r; int lat;
    do_write(0, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, r, lat);
    total++; if (r !== 2'b00 || lat != 1) $display("FAIL basic_wr resp/lat got %b/%0d want 00/1", r, lat); else passed++;
    do_read(0, 32'h8000_0010, d, r, lat);
    total++; if (d !== 32'hDEAD_BEEF) $display("FAIL basic_rd_data got %h want deadbeef", d); else passed++;
    total++; if (r !== 2'b00 || lat != 1) $display("FAIL basic_rd resp/lat got %b/%0d want 00/1", r, lat); else passed++;
    // wstrb=0 leaves the word alone but still answers OKAY
    do_write(0, 32'h8000_0010, 32'h0, 4'h0, r, lat);
    total++; if (r !== 2'b00) $display("FAIL strb0_resp got %b want 00", r); else passed++;
    do_read(0, 32'h8000_0012, d, r, lat);
    total++; if (d !== 32'hDEAD_BEEF) $display("FAIL strb0_data got %h want deadbeef", d); else passed++;
  endtask

  task automatic test_strobe();
    logic [31:0] d; logic [1:0] r; int lat;
    do_write(0, 32'h8000_0014, 32'h1122_3344, 4'hF, r, lat);
    do_write(0, 32'h8000_0014, 32'hAABB_CCDD, 4'h5, r, lat);
    do_read(0, 32'h8000_0014, d, r, lat);
    total++; if (d !== 32'h11BB_33DD) $display("FAIL strobe_data got %h want 11bb33dd", d); else passed++;
  endtask

  task automatic test_decode();
    logic [31:0] d; logic [1:0] r; int lat;
    do_read(0, 32'h0000_1000, d, r, lat);
    total++; if (r !== 2'b11 || d !== 32'h0) $display("FAIL oor_rd got %b/%h want 11/0", r, d); else passed++;
    do_read(0, 32'h8000_4000, d, r, lat);
    total++; if (r !== 2'b11) $display("FAIL oor_rd_top got %b want 11", r); else passed++;
    do_write(0, 32'h8000_0000, 32'h5A5A_0001, 4'hF, r, lat);
    do_write(0, 32'h9000_0000, 32'hFFFF_FFFF, 4'hF, r, lat);
    total++; if (r !== 2'b11) $display("FAIL oor_wr_resp got %b want 11", r); else passed++;
    do_read(0, 32'h8000_0000, d, r, lat);
    total++; if (d !== 32'h5A5A_0001) $display("FAIL oor_base_word got %h want 5a5a0001", d); else passed++;
    do_write(0, 32'h8000_3FFC, 32'h7777_8888, 4'hF, r, lat);
    do_read(0, 32'h8000_3FFC, d, r, lat);
    total++; if (d !== 32'h7777_8888 || r !== 2'b00) $display("FAIL last_word got %h/%b want 77778888/00", d, r); else passed++;
  endtask

  task automatic test_w_before_aw();
    logic [31:0] d; logic [1:0] r; int lat;
    wvalid[0] = 1'b1; wdata[0] = 32'h600D_CAFE; wstrb[0] = 4'hF;
    awaddr[0] = 32'h8000_0030;
    @(negedge clk);
    wvalid[0] = 1'b0;
    total++; if (wready[0] !== 1'b0 || awready[0] !== 1'b1)
      $display("FAIL wfirst_ready got w%b aw%b want w0 aw1", wready[0], awready[0]); else passed++;
    repeat (2) @(negedge clk);
    total++; if (wready[0] !== 1'b0 || bvalid[0] !== 1'b0)
      $display("FAIL wfirst_hold got w%b b%b want w0 b0", wready[0], bvalid[0]); else passed++;
    awvalid[0] = 1'b1;
    @(negedge clk);
    awvalid[0] = 1'b0;
    total++; if (bvalid[0] !== 1'b1 || bresp[0] !== 2'b00)
      $display("FAIL wfirst_b got %b/%b want 1/00", bvalid[0], bresp[0]); else passed++;
    @(negedge clk);
    total++; if ({bvalid[0], awready[0], wready[0]} !== 3'b011)
      $display("FAIL wfirst_done got %b want 011", {bvalid[0], awready[0], wready[0]}); else passed++;
    do_read(0, 32'h8000_0030, d, r, lat);
    total++; if (d !== 32'h600D_CAFE) $display("FAIL wfirst_data got %h want 600dcafe", d); else passed++;
  endtask

  task automatic test_backpressure();
    logic [31:0] d0; logic [1:0] r; int lat;
    do_write(1, 32'h8000_0040, 32'h0BAD_F00D, 4'hF, r, lat);
    total++; if (lat != 4 || r !== 2'b00) $display("FAIL fix3_wr lat/resp got %0d/%b want 4/00", lat, r); else passed++;
    rready[1] = 1'b0; arvalid[1] = 1'b1; araddr[1] = 32'h8000_0040;
    @(negedge clk);
    arvalid[1] = 1'b0;
    lat = 1;
    while (!rvalid[1] && lat < 20) begin @(negedge clk); lat++; end
    total++; if (lat != 4) $display("FAIL fix3_rd_lat got %0d want 4", lat); else passed++;
    d0 = rdata[1];
    total++; if (d0 !== 32'h0BAD_F00D) $display("FAIL fix3_rd_data got %h want 0badf00d", d0); else passed++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if (rvalid[1] !== 1'b1 || rdata[1] !== 32'h0BAD_F00D)
        $display("FAIL bp_hold c%0d got %b/%h want 1/0badf00d", i, rvalid[1], rdata[1]);
      else passed++;
    end
    rready[1] = 1'b1;
    @(negedge clk);
    total++; if (rvalid[1] !== 1'b0) $display("FAIL bp_release got %b want 0", rvalid[1]); else passed++;
  endtask

  task automatic test_reset_midwrite();
    logic [31:0] d; logic [1:0] r; int lat; bit seen = 0;
    do_write(1, 32'h8000_0020, 32'hCAFE_F00D, 4'hF, r, lat);
    awvalid[1] = 1'b1; awaddr[1] = 32'h8000_0020;
    wvalid[1]  = 1'b1; wdata[1]  = 32'h1234_5678; wstrb[1] = 4'hF;
    @(negedge clk);
    awvalid[1] = 1'b0; wvalid[1] = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++; if ({awready[1], wready[1], bvalid[1], rvalid[1]} !== 4'b1100 || rdata[1] !== 32'h0)
      $display("FAIL midrst_outs got %b/%h want 1100/0", {awready[1], wready[1], bvalid[1], rvalid[1]}, rdata[1]);
    else passed++;
    for (int i = 0; i < 6; i++) begin
      if (bvalid[1]) seen = 1;
      @(negedge clk);
    end
    total++; if (seen) $display("FAIL midrst_bvalid got 1 want 0"); else passed++;
    do_read(1, 32'h8000_0020, d, r, lat);
    total++; if (d !== 32'hCAFE_F00D) $display("FAIL midrst_data got %h want cafef00d", d); else passed++;
  endtask

  task automatic test_random();
    logic [31:0] ref_mem [16];
    logic [31:0] d, a, wd, exp_d; logic [1:0] r; logic [3:0] s; int lat, k; bit bad;
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = $urandom;
      do_write(2, BASE + 32'(i * 4), ref_mem[i], 4'hF, r, lat);
      total++; if (r !== 2'b00) $display("FAIL rnd_init i%0d got %b want 00", i, r); else passed++;
    end
    for (int t = 0; t < 1000; t++) begin
      bad = ($urandom_range(0, 9) == 0);
      k   = $urandom_range(0, 15);
      if (!bad)                         a = BASE + 32'(k * 4) + 32'($urandom_range(0, 3));
      else if ($urandom_range(0, 1) == 1) a = 32'h8000_4000 + 32'(k * 4);
      else                              a = $urandom & 32'h7FFF_FFFF;
      if ($urandom_range(0, 1) == 1) begin
        wd = $urandom; s = 4'($urandom_range(0, 15));
        do_write(2, a, wd, s, r, lat);
        if (!bad)
          for (int b = 0; b < 4; b++) if (s[b]) ref_mem[k][8*b +: 8] = wd[8*b +: 8];
        total++; if (r !== (bad ? 2'b11 : 2'b00)) $display("FAIL rnd_bresp t%0d got %b want %b", t, r, bad ? 2'b11 : 2'b00); else passed++;
      end else begin
        do_read(2, a, d, r, lat);
        exp_d = bad ? 32'h0 : ref_mem[k];
        total++; if (d !== exp_d || r !== (bad ? 2'b11 : 2'b00))
          $display("FAIL rnd_rd t%0d a=%h got %h/%b want %h/%b", t, a, d, r, exp_d, bad ? 2'b11 : 2'b00);
        else passed++;
      end
      total++; if (lat < 1 || lat > 4) $display("FAIL rnd_lat t%0d got %0d want 1..4", t, lat); else passed++;
    end
  endtask

  initial begin
    for (int u = 0; u < N; u++) begin
      awvalid[u] = 0; wvalid[u] = 0; arvalid[u] = 0;
      bready[u] = 1; rready[u] = 1;
      awaddr[u] = '0; araddr[u] = '0; wdata[u] = '0; wstrb[u] = '0;
    end
    test_reset();
    test_basic();
    test_strobe();
    test_decode();
    test_w_before_aw();
    test_backpressure();
    test_reset_midwrite();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
